divider_4bit: RTL and testbench

Sequential unsigned restoring divider for the ALU datapath. It produces a quotient and a remainder from a dividend and a divisor, using one trial subtraction per cycle. The subtract step is the same two's-complement add-with-inverted-operand scheme the datapath's add/sub unit uses. A start/busy/done handshake connects it to the control FSM, so divide can share the ALU result path with the single-cycle add/sub operations.

---
 rtl/divider_4bit.sv | 152 +++++++++++++++
 tb/tb_divider_4bit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_4bit.sv
`default_nettype none
// ============================================================================
// Module   : divider_4bit
// Brief    : Sequential unsigned restoring divider, one trial subtraction per
//            cycle, with start/busy/done handshake and divide-by-zero flag.
//            All outputs are registered copies of the internal state, so they
//            trail the FSM by one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dvz
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       r_q, r_d;        // partial remainder
  logic [WIDTH-1:0]     q_q, q_d;        // shifting dividend / quotient
  logic [WIDTH-1:0]     d_q, d_d;        // captured divisor
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;    // steps remaining
  logic                 zf_q, zf_d;      // divide-by-zero flag of the current op

  logic                 busy_q, done_q, dvz_q;
  logic [WIDTH-1:0]     quot_q, rem_q;

  logic [WIDTH:0]       w_shift;
  logic [WIDTH+1:0]     w_sum;
  logic                 w_no_borrow;
  logic                 w_accept_nz;

  // Trial subtraction: shifted remainder plus inverted divisor plus one;
  // a carry out of the top bit means the subtraction did not borrow.
  always_comb begin
    w_shift     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    w_sum       = {1'b0, w_shift} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    w_no_borrow = w_sum[WIDTH+1];
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    zf_d        = zf_q;
    w_accept_nz = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d         = '0;
            q_d         = dividend;
            d_d         = divisor;
            cnt_d       = c_cnt_w'(WIDTH);
            zf_d        = 1'b0;
            state_d     = S_RUN;
            w_accept_nz = (state_q == S_IDLE);
          end else begin
            r_d     = {1'b0, dividend};
            q_d     = '1;
            d_d     = divisor;
            zf_d    = 1'b1;
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_no_borrow) begin
          r_d = w_sum[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = w_shift;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      zf_q    <= zf_d;
    end
  end

  // Registered outputs: status mirrors the state one cycle later, results
  // are captured while the FSM sits in DONE and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dvz_q  <= 1'b0;
    end else begin
      busy_q <= (state_q == S_RUN);
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        quot_q <= q_q;
        rem_q  <= r_q[WIDTH-1:0];
        dvz_q  <= zf_q;
      end else if (w_accept_nz) begin
        dvz_q  <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dvz       = dvz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_4bit
// Brief    : Self-checking bench for divider_4bit; expected results come from
//            plain integer division and modulo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dvz;

  int errors = 0;
  int checks = 0;

  divider_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dvz       (dvz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer division, or the all-ones / dividend / flag result
  // for a zero divisor.
  function automatic void ref_div(input int a, input int b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic z);
    if (b == 0) begin
      q = 4'hF;
      r = 4'(a);
      z = 1'b1;
    end else begin
      q = 4'(a / b);
      r = 4'(a % b);
      z = 1'b0;
    end
  endfunction

  // Issue one start, wait (bounded) for done, return results and latency.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit scramble,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic z, output int lat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (scramble) begin
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = dvz;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_quot: got %0d expected 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_rem: got %0d expected 0", remainder); end
    checks++; if (dvz !== 1'b0) begin errors++; $display("FAIL reset_dvz: got %b expected 0", dvz); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_edge0: got busy=%b done=%b expected 0 0", busy, done);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'(k <= 4) || done !== 1'(k == 5)) begin
        errors++;
        $display("FAIL basic_cycle%0d: got busy=%b done=%b expected %b %b", k, busy, done, k <= 4, k == 5);
      end
    end
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || dvz !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dvz=%b expected 4 1 0", quotient, remainder, dvz);
    end
  endtask

  task automatic test_cases;
    int ca[5] = '{13, 15, 2, 15, 0};
    int cb[5] = '{3, 1, 7, 15, 5};
    int eq[5] = '{4, 15, 0, 1, 0};
    int er[5] = '{1, 0, 2, 0, 0};
    logic [3:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(4'(ca[i]), 4'(cb[i]), 1'b0, q, r, z, lat);
      checks++;
      if (q !== 4'(eq[i]) || r !== 4'(er[i]) || z !== 1'b0 || lat != 5) begin
        errors++;
        $display("FAIL case_%0d_%0d: got q=%0d r=%0d dvz=%b lat=%0d expected %0d %0d 0 5",
                 ca[i], cb[i], q, r, z, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [3:0] q, r, eq, er;
    logic z, ez;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b0, q, r, z, lat);
        ref_div(a, b, eq, er, ez);
        checks++;
        if (q !== eq || r !== er || z !== ez || lat != ((b == 0) ? 1 : 5)) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dvz=%b lat=%0d expected %0d %0d %b %0d",
                   a, b, q, r, z, lat, eq, er, ez, (b == 0) ? 1 : 5);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      if ($urandom_range(0, 3) == 0) b = 4'd0;
      run_op(a, b, 1'b1, q, r, z, lat);
      ref_div(int'(a), int'(b), eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
        errors++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dvz=%b expected %0d %0d %b", a, b, q, r, z, eq, er, ez);
      end
    end
  endtask

  task automatic test_dvz;
    logic [3:0] q, r;
    logic z;
    int lat;
    start = 1'b1; dividend = 4'd9; divisor = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL dvz_edge0: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dvz_done: got busy=%b done=%b expected 0 1", busy, done);
    end
    checks++;
    if (quotient !== 4'd15 || remainder !== 4'd9 || dvz !== 1'b1) begin
      errors++; $display("FAIL dvz_result: got q=%0d r=%0d dvz=%b expected 15 9 1", quotient, remainder, dvz);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dvz_after: got busy=%b done=%b expected 0 0", busy, done);
    end
    run_op(4'd8, 4'd2, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 4'd4 || r !== 4'd0 || z !== 1'b0 || lat != 5) begin
      errors++; $display("FAIL dvz_follow: got q=%0d r=%0d dvz=%b lat=%0d expected 4 0 0 5", q, r, z, lat);
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int at = -1;
    logic [3:0] q = 4'd0;
    logic [3:0] r = 4'd0;
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      @(posedge clk); #1;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      if (done === 1'b1) begin
        ndone++;
        at = k;
        q  = quotient;
        r  = remainder;
      end
    end
    checks++;
    if (ndone != 1 || at != 5) begin
      errors++; $display("FAIL ignore_done: got count=%0d at=%0d expected 1 at 5", ndone, at);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1) begin
      errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected 4 1", q, r);
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd2) begin
      errors++; $display("FAIL b2b_first: got done=%b q=%0d r=%0d expected 1 3 2", done, quotient, remainder);
    end
    for (int k = 6; k <= 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL b2b_run%0d: got busy=%b done=%b expected 1 0", k, busy, done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1 || dvz !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got done=%b busy=%b q=%0d r=%0d dvz=%b expected 1 0 3 1 0",
               done, busy, quotient, remainder, dvz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int nd = 0;
    logic [3:0] q, r;
    logic z;
    int lat;
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0 || dvz !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b q=%0d r=%0d dvz=%b expected all 0",
               busy, done, quotient, remainder, dvz);
    end
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", nd);
    end
    run_op(4'd10, 4'd3, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 4'd3 || r !== 4'd1 || z !== 1'b0 || lat != 5) begin
      errors++; $display("FAIL abort_restart: got q=%0d r=%0d dvz=%b lat=%0d expected 3 1 0 5", q, r, z, lat);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    test_reset;
    test_basic;
    test_cases;
    test_sweep;
    test_random;
    test_dvz;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
